// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared constants and helpers for the Gray-pointer FIFO.
//   SYNC_STAGES : flops in each pointer synchronizer chain
//   addr_width  : memory address width for a given entry count
//   bin2gray    : binary to reflected Gray code (callers truncate to their width)
package async_fifo_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/async_fifo_ram.sv
// async_fifo_ram: simple dual-port storage for async_fifo.
//   clk           : single clock for both ports
//   rst           : synchronous active-high reset (clears the read register only)
//   we/waddr/wdata: write port, stored on the rising edge when we = 1
//   re/raddr/rdata: registered read port; rdata updates only when re = 1
// A read and write to the same address in one cycle returns the old word.
module async_fifo_ram
    import async_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with Gray-coded pointers and 2-flop pointer
// synchronizers, keeping the handshake of a future dual-clock version.
//   clk    : clock, all state on the rising edge
//   rst    : synchronous active-high reset
//   winc   : write request, accepted when wfull = 0
//   wdata  : write data
//   rinc   : read request, accepted when rempty = 0
//   wfull  : full flag (combinational from registers, conservative on deassert)
//   rempty : empty flag (combinational from registers, conservative on deassert)
//   rdata  : registered read data, valid one cycle after an accepted read
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,  // power of 2, >= 4
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rinc,
    output logic             wfull,
    output logic             rempty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned AW = addr_width(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next;
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next;
    logic [PW-1:0] wsync [SYNC_STAGES];  // wgray -> wq1 -> wq2
    logic [PW-1:0] rsync [SYNC_STAGES];  // rgray -> rq1 -> rq2
    logic [PW-1:0] wq2, rq2;
    logic          wen, ren;

    assign wen = winc & ~wfull;
    assign ren = rinc & ~rempty;

    always_comb begin
        wbin_next  = wbin + PW'(1);
        rbin_next  = rbin + PW'(1);
        wgray_next = PW'(bin2gray(32'(wbin_next)));
        rgray_next = PW'(bin2gray(32'(rbin_next)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin  <= '0;
            wgray <= '0;
        end else if (wen) begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbin  <= '0;
            rgray <= '0;
        end else if (ren) begin
            rbin  <= rbin_next;
            rgray <= rgray_next;
        end
    end

    // Each side only sees the other's pointer after SYNC_STAGES edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wsync[i] <= '0;
                rsync[i] <= '0;
            end
        end else begin
            wsync[0] <= wgray;
            rsync[0] <= rgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wsync[i] <= wsync[i-1];
                rsync[i] <= rsync[i-1];
            end
        end
    end

    assign wq2 = wsync[SYNC_STAGES-1];
    assign rq2 = rsync[SYNC_STAGES-1];

    // Full when write pointer is exactly one lap ahead: in Gray code that is
    // the top two bits inverted and the rest equal.
    assign rempty = (rgray == wq2);
    assign wfull  = (wgray == {~rq2[AW:AW-1], rq2[AW-2:0]});

    async_fifo_ram #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wen),
        .waddr(wbin[AW-1:0]),
        .wdata(wdata),
        .re   (ren),
        .raddr(rbin[AW-1:0]),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: a directed vector table, hand-written corner
// sequences and a randomized run against a queue-and-counter reference.
module tb_async_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             winc = 1'b0;
    logic             rinc = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic             wfull, rempty;
    logic [WIDTH-1:0] rdata;

    always #5 clk = ~clk;

    async_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .winc  (winc),
        .wdata (wdata),
        .rinc  (rinc),
        .wfull (wfull),
        .rempty(rempty),
        .rdata (rdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference: stored words in a queue, plus accepted-operation counts.
    // The opposite side's count is seen two edges late.
    logic [7:0] mq [$];
    int         nw = 0, nr = 0;
    int         nw_h1 = 0, nw_h2 = 0, nr_h1 = 0, nr_h2 = 0;
    logic [7:0] m_rdata = '0;
    logic       m_empty = 1'b1, m_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic rs, input logic w, input logic [7:0] d,
                              input logic r, output logic wa, output logic ra);
        wa = 1'b0;
        ra = 1'b0;
        if (rs) begin
            mq.delete();
            nw = 0; nr = 0; nw_h1 = 0; nw_h2 = 0; nr_h1 = 0; nr_h2 = 0;
            m_rdata = '0;
        end else begin
            wa = w && !m_full;
            ra = r && !m_empty;
            nw_h2 = nw_h1; nw_h1 = nw;
            nr_h2 = nr_h1; nr_h1 = nr;
            if (ra) begin
                m_rdata = mq.pop_front();
                nr++;
            end
            if (wa) begin
                mq.push_back(d);
                nw++;
            end
        end
        m_empty = (nr == nw_h2);
        m_full  = ((nw - nr_h2) == DEPTH);
    endtask

    // One clock: drive, step the model at the edge, compare 1 time unit later.
    task automatic cycle(input logic rs, input logic w, input logic [7:0] d, input logic r,
                         input string tag, output logic wa, output logic ra);
        rst = rs; winc = w; wdata = d; rinc = r;
        @(posedge clk);
        model_step(rs, w, d, r, wa, ra);
        #1;
        check({tag, " rempty"}, 32'(rempty), 32'(m_empty));
        check({tag, " wfull"},  32'(wfull),  32'(m_full));
        check({tag, " rdata"},  32'(rdata),  32'(m_rdata));
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    endtask

    typedef struct {
        logic       rs;
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       e;
        logic       f;
        logic [7:0] q;
    } vec_t;

    vec_t vt [17];

    initial begin
        logic wa, ra;
        int   next_w, nread, n_aa, cnt;

        // rs, w, d, r -> expected rempty, wfull, rdata (after the edge)
        vt[0]  = '{1, 0, 8'h00, 0, 1, 0, 8'h00};
        for (int i = 1; i <= 5; i++) vt[i] = '{0, 0, 8'h00, 0, 1, 0, 8'h00};
        vt[6]  = '{0, 1, 8'h11, 0, 1, 0, 8'h00};  // first write
        vt[7]  = '{0, 0, 8'h00, 0, 1, 0, 8'h00};
        vt[8]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00};  // empty falls 2 edges later
        vt[9]  = '{0, 0, 8'h00, 1, 1, 0, 8'h11};  // read
        vt[10] = '{0, 0, 8'h00, 1, 1, 0, 8'h11};  // read while empty ignored
        vt[11] = '{0, 1, 8'h22, 1, 1, 0, 8'h11};  // read ignored, write taken
        vt[12] = '{0, 0, 8'h00, 0, 1, 0, 8'h11};
        vt[13] = '{0, 0, 8'h00, 0, 0, 0, 8'h11};
        vt[14] = '{1, 1, 8'h33, 0, 1, 0, 8'h00};  // reset drops data, write ignored
        vt[15] = '{0, 0, 8'h00, 0, 1, 0, 8'h00};
        vt[16] = '{0, 0, 8'h00, 0, 1, 0, 8'h00};

        for (int i = 0; i < 17; i++) begin
            rst = vt[i].rs; winc = vt[i].w; wdata = vt[i].d; rinc = vt[i].r;
            @(posedge clk);
            model_step(vt[i].rs, vt[i].w, vt[i].d, vt[i].r, wa, ra);
            #1;
            check($sformatf("vec%0d rempty", i), 32'(rempty), 32'(vt[i].e));
            check($sformatf("vec%0d wfull", i),  32'(wfull),  32'(vt[i].f));
            check($sformatf("vec%0d rdata", i),  32'(rdata),  32'(vt[i].q));
        end

        // Continuous writes of 1: empty falls after 2 edges, full after 16th.
        cycle(1, 0, 8'h00, 0, "A rst", wa, ra);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 8'h01, 0, "A fill", wa, ra);
            check($sformatf("A%0d rempty", i), 32'(rempty), 32'(i < 2));
            check($sformatf("A%0d wfull", i),  32'(wfull),  32'(i >= 15));
        end

        // Fill 0x00..0x0F then drain in order.
        cycle(1, 0, 8'h00, 0, "B rst", wa, ra);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 0, "B fill", wa, ra);
        cycle(0, 0, 8'h00, 0, "B idle", wa, ra);
        cycle(0, 0, 8'h00, 0, "B idle", wa, ra);
        for (int j = 0; j < 16; j++) begin
            cycle(0, 0, 8'h00, 1, "B drain", wa, ra);
            check($sformatf("B%0d rdata", j),  32'(rdata),  32'(j));
            check($sformatf("B%0d wfull", j),  32'(wfull),  32'(j < 2));
            check($sformatf("B%0d rempty", j), 32'(rempty), 32'(j == 15));
        end

        // 40 words streamed through with concurrent reads, crossing the wrap.
        cycle(1, 0, 8'h00, 0, "C rst", wa, ra);
        next_w = 0;
        nread  = 0;
        for (int c = 0; c < 400 && nread < 40; c++) begin
            cycle(0, next_w < 40, 8'(8'h10 + next_w), !m_empty, "C", wa, ra);
            if (wa) next_w++;
            if (ra) begin
                check($sformatf("C word%0d", nread), 32'(rdata), 32'(8'h10 + nread));
                nread++;
            end
        end
        check("C words read", 32'(nread), 32'd40);

        // Full: simultaneous read+write takes the read and drops the write.
        cycle(1, 0, 8'h00, 0, "D rst", wa, ra);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(8'h80 + i), 0, "D fill", wa, ra);
        cycle(0, 0, 8'h00, 0, "D idle", wa, ra);
        cycle(0, 0, 8'h00, 0, "D idle", wa, ra);
        cycle(0, 1, 8'hAA, 1, "D both", wa, ra);
        check("D read accepted", 32'(rdata), 32'h80);
        check("D still full", 32'(wfull), 32'd1);
        n_aa = 0;
        cnt  = 1;
        for (int c = 0; c < 60 && cnt < 17; c++) begin
            cycle(0, 0, 8'h00, !m_empty, "D drain", wa, ra);
            if (ra) begin
                if (rdata == 8'hAA) n_aa++;
                cnt++;
            end
        end
        for (int c = 0; c < 3; c++) cycle(0, 0, 8'h00, 1, "D tail", wa, ra);
        check("D words read", 32'(cnt), 32'd16);
        check("D 0xAA seen", 32'(n_aa), 32'd0);
        check("D empty at end", 32'(rempty), 32'd1);

        // Reset with 5 words stored.
        cycle(1, 0, 8'h00, 0, "E rst", wa, ra);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h60 + i), 0, "E fill", wa, ra);
        cycle(0, 0, 8'h00, 0, "E idle", wa, ra);
        cycle(0, 0, 8'h00, 0, "E idle", wa, ra);
        cycle(0, 0, 8'h00, 1, "E read", wa, ra);
        cycle(1, 0, 8'h00, 0, "E rst2", wa, ra);
        check("E rempty", 32'(rempty), 32'd1);
        check("E wfull",  32'(wfull),  32'd0);
        check("E rdata",  32'(rdata),  32'd0);
        cycle(0, 1, 8'h5A, 0, "E wr", wa, ra);
        cycle(0, 0, 8'h00, 0, "E idle", wa, ra);
        cycle(0, 0, 8'h00, 0, "E idle", wa, ra);
        cycle(0, 0, 8'h00, 1, "E rd", wa, ra);
        check("E readback", 32'(rdata), 32'h5A);

        // Randomized traffic with phases biased toward filling or draining.
        for (int c = 0; c < 3000; c++) begin
            logic fillph;
            fillph = ((c / 150) % 2) == 0;
            cycle($urandom_range(0, 249) == 0,
                  fillph ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  8'($urandom_range(0, 255)),
                  fillph ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  "R", wa, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
